adc_capture: RTL and testbench



---
 rtl/adc_capture_if.sv | 26 ++
 rtl/adc_capture.sv | 161 ++++++++++++++++
 tb/tb_adc_capture.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_if.sv
// rtl/adc_capture_if.sv - ADC pins, trigger controls and readout port of the capture stage
interface adc_capture_if #(
   parameter int DEPTH_BITS = 9
);
   logic [7:0]            ADC_D;
   logic                  ADC_CLK;
   logic                  ADC_nOE;
   logic                  ARM;
   logic [7:0]            TRIG_LEVEL;
   logic                  TRIG_RISING;
   logic                  FORCE_TRIG;
   logic                  BUSY;
   logic                  DONE;
   logic [DEPTH_BITS-1:0] RD_ADDR;
   logic [7:0]            RD_DATA;

   modport master (
      output ADC_D, ARM, TRIG_LEVEL, TRIG_RISING, FORCE_TRIG, RD_ADDR,
      input  ADC_CLK, ADC_nOE, BUSY, DONE, RD_DATA
   );

   modport slave (
      input  ADC_D, ARM, TRIG_LEVEL, TRIG_RISING, FORCE_TRIG, RD_ADDR,
      output ADC_CLK, ADC_nOE, BUSY, DONE, RD_DATA
   );
endinterface

// File: rtl/adc_capture.sv
// rtl/adc_capture.sv - ADC clocking, edge trigger with pre-trigger history, circular capture buffer
module adc_capture #(
   parameter int CLK_DIV    = 4,
   parameter int DEPTH_BITS = 9,
   parameter int PRETRIG    = 128
) (
   input  logic          CLK,
   input  logic          RST,
   adc_capture_if.slave  bus
);
   localparam int DEPTH  = 1 << DEPTH_BITS;
   localparam int POST_N = DEPTH - PRETRIG;
   localparam int HALF   = CLK_DIV / 2;
   localparam int DIV_W  = $clog2(CLK_DIV);
   localparam int CNT_W  = DEPTH_BITS + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_WAIT,
      S_POST,
      S_DONE
   } state_t;

   state_t                state, state_nxt;
   logic [DIV_W-1:0]      div_cnt, div_nxt;
   logic                  sample_evt;
   logic                  adc_clk_r;
   logic                  adc_noe_r;
   logic [7:0]            sample;
   logic [DEPTH_BITS-1:0] wr_ptr;
   logic [DEPTH_BITS-1:0] start_ptr;
   logic [CNT_W-1:0]      cnt;
   logic                  rise_hit, fall_hit, trig_hit;
   logic                  wr_en;
   logic                  busy, done;
   logic [7:0]            rd_data;
   logic [7:0]            mem [DEPTH];

   // Sample edge is the last CLK edge before ADC_CLK rises, so ADC_D has settled.
   always_comb begin
      sample_evt = (div_cnt == DIV_W'(CLK_DIV - 1));
      div_nxt    = sample_evt ? '0 : div_cnt + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         div_cnt   <= '0;
         adc_clk_r <= 1'b0;
         adc_noe_r <= 1'b1;
         sample    <= '0;
      end else begin
         div_cnt   <= div_nxt;
         adc_clk_r <= (div_nxt < DIV_W'(HALF));
         adc_noe_r <= 1'b0;
         if (sample_evt)
            sample <= bus.ADC_D;
      end
   end

   // Current sample is ADC_D at the sample edge; `sample` holds the previous one.
   always_comb begin
      rise_hit = (sample <  bus.TRIG_LEVEL) && (bus.ADC_D >= bus.TRIG_LEVEL);
      fall_hit = (sample >= bus.TRIG_LEVEL) && (bus.ADC_D <  bus.TRIG_LEVEL);
      trig_hit = sample_evt &&
                 (bus.FORCE_TRIG || (bus.TRIG_RISING ? rise_hit : fall_hit));
   end

   always_ff @(posedge CLK) begin
      if (RST)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (bus.ARM)
               state_nxt = S_PRE;
         end
         S_PRE: begin
            if (sample_evt && cnt == CNT_W'(PRETRIG - 1))
               state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (trig_hit)
               state_nxt = (POST_N == 1) ? S_DONE : S_POST;
         end
         S_POST: begin
            if (sample_evt && cnt == CNT_W'(POST_N - 1))
               state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy  = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
      done  = (state == S_DONE);
      wr_en = busy && sample_evt;
   end

   // cnt counts pre-trigger samples in PRE and post-trigger samples (trigger included) in POST.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr    <= '0;
         start_ptr <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.ARM) begin
                  wr_ptr <= '0;
                  cnt    <= '0;
               end
            end
            S_PRE: begin
               if (sample_evt) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  cnt    <= (cnt == CNT_W'(PRETRIG - 1)) ? '0 : cnt + 1'b1;
               end
            end
            S_WAIT: begin
               if (sample_evt)
                  wr_ptr <= wr_ptr + 1'b1;
               if (trig_hit) begin
                  start_ptr <= wr_ptr - DEPTH_BITS'(PRETRIG);
                  cnt       <= CNT_W'(1);
               end
            end
            S_POST: begin
               if (sample_evt) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  cnt    <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_en)
         mem[wr_ptr] <= bus.ADC_D;
   end

   always_ff @(posedge CLK) begin
      if (RST)
         rd_data <= '0;
      else
         rd_data <= mem[start_ptr + bus.RD_ADDR];
   end

   assign bus.ADC_CLK = adc_clk_r;
   assign bus.ADC_nOE = adc_noe_r;
   assign bus.BUSY    = busy;
   assign bus.DONE    = done;
   assign bus.RD_DATA = rd_data;
endmodule

// File: tb/tb_adc_capture.sv
// tb/tb_adc_capture.sv - directed bench for adc_capture with a ramp/constant ADC model
module tb_adc_capture;
   logic       clk;
   logic       rst;
   int         checks;
   int         failures;
   int         mode;
   logic [7:0] base;
   logic [7:0] ofs;
   logic       clk_hist [8];

   adc_capture_if #(.DEPTH_BITS(4)) ifc ();

   adc_capture #(
      .CLK_DIV   (4),
      .DEPTH_BITS(4),
      .PRETRIG   (4)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .bus(ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ADC model: base advances once per ADC_CLK rise; mode 0 up-ramp, 1 down-ramp, 2 constant.
   initial base = 8'h00;
   always @(posedge ifc.ADC_CLK) begin
      #3;
      base = base + 8'h01;
   end
   assign ifc.ADC_D = (mode == 0) ? ofs + base : (mode == 1) ? ofs - base : ofs;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input string tag, input int bound);
      int n = 0;
      while (ifc.DONE !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
      chk(tag, 32'(ifc.DONE), 32'd1);
   endtask

   task automatic wait_adc(input string tag, input logic [7:0] v, input int bound);
      int n = 0;
      while (ifc.ADC_D !== v && n < bound) begin
         tick();
         n++;
      end
      chk(tag, 32'(ifc.ADC_D), 32'(v));
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
      ifc.RD_ADDR = a;
      tick();
      chk(tag, 32'(ifc.RD_DATA), 32'(exp));
   endtask

   task automatic set_ramp(input int m, input logic [7:0] v);
      mode = m;
      if (m == 0)
         ofs = v - base;
      else if (m == 1)
         ofs = v + base;
      else
         ofs = v;
   endtask

   task automatic arm();
      ifc.ARM = 1'b1;
      tick();
      ifc.ARM = 1'b0;
   endtask

   initial begin
      checks           = 0;
      failures         = 0;
      mode             = 2;
      ofs              = 8'h00;
      rst              = 1'b1;
      ifc.ARM          = 1'b0;
      ifc.TRIG_LEVEL   = 8'h40;
      ifc.TRIG_RISING  = 1'b1;
      ifc.FORCE_TRIG   = 1'b0;
      ifc.RD_ADDR      = '0;

      // Reset state
      repeat (5) tick();
      chk("rst_noe", 32'(ifc.ADC_nOE), 32'd1);
      chk("rst_busy", 32'(ifc.BUSY), 32'd0);
      chk("rst_done", 32'(ifc.DONE), 32'd0);
      chk("rst_adcclk", 32'(ifc.ADC_CLK), 32'd0);
      chk("rst_rddata", 32'(ifc.RD_DATA), 32'd0);
      rst = 1'b0;
      tick();
      chk("noe_release", 32'(ifc.ADC_nOE), 32'd0);
      clk_hist[0] = ifc.ADC_CLK;
      for (int i = 1; i < 8; i++) begin
         tick();
         clk_hist[i] = ifc.ADC_CLK;
      end
      for (int i = 0; i < 4; i++)
         chk("adcclk_period", 32'(clk_hist[i + 4]), 32'(clk_hist[i]));
      for (int i = 0; i < 6; i++)
         chk("adcclk_halfduty", 32'(clk_hist[i] ^ clk_hist[i + 2]), 32'd1);

      // Rising trigger on an up-ramp from 0x00
      set_ramp(0, 8'h00);
      ifc.TRIG_LEVEL  = 8'h40;
      ifc.TRIG_RISING = 1'b1;
      arm();
      chk("rise_busy_after_arm", 32'(ifc.BUSY), 32'd1);
      wait_done("rise_done", 2000);
      chk("rise_busy_at_done", 32'(ifc.BUSY), 32'd0);
      for (int i = 0; i < 16; i++)
         rd_chk("rise_rd", 4'(i), 8'h3C + 8'(i));
      ifc.RD_ADDR = 4'd4;
      chk("rise_rd_latency_old", 32'(ifc.RD_DATA), 32'h4B);
      tick();
      chk("rise_rd_latency_new", 32'(ifc.RD_DATA), 32'h40);

      // Falling trigger on a down-ramp from 0xFF, re-armed from DONE
      set_ramp(1, 8'hFF);
      ifc.TRIG_LEVEL  = 8'h80;
      ifc.TRIG_RISING = 1'b0;
      arm();
      chk("fall_done_drops", 32'(ifc.DONE), 32'd0);
      chk("fall_busy", 32'(ifc.BUSY), 32'd1);
      wait_done("fall_done", 2000);
      rd_chk("fall_rd4", 4'd4, 8'h7F);
      rd_chk("fall_rd0", 4'd0, 8'h83);
      rd_chk("fall_rd15", 4'd15, 8'h74);

      // Constant input never crosses; only FORCE_TRIG ends the wait
      set_ramp(2, 8'h80);
      ifc.TRIG_LEVEL  = 8'h80;
      ifc.TRIG_RISING = 1'b1;
      arm();
      repeat (400) tick();
      chk("force_still_busy", 32'(ifc.BUSY), 32'd1);
      chk("force_not_done", 32'(ifc.DONE), 32'd0);
      ifc.FORCE_TRIG = 1'b1;
      repeat (4) tick();
      ifc.FORCE_TRIG = 1'b0;
      wait_done("force_done", 200);
      for (int i = 0; i < 16; i++)
         rd_chk("force_rd", 4'(i), 8'h80);

      // Crossing inside PRE is masked; trigger comes after the ramp wraps
      set_ramp(0, 8'h00);
      ifc.TRIG_LEVEL  = 8'h02;
      ifc.TRIG_RISING = 1'b1;
      arm();
      repeat (200) tick();
      chk("pre_mask_busy", 32'(ifc.BUSY), 32'd1);
      wait_done("pre_mask_done", 3000);
      rd_chk("pre_mask_rd4", 4'd4, 8'h02);
      rd_chk("pre_mask_rd0", 4'd0, 8'hFE);
      rd_chk("pre_mask_rd5", 4'd5, 8'h03);

      // ARM during WAIT must not restart (a restart would mask the 0x40 crossing)
      set_ramp(0, 8'h20);
      ifc.TRIG_LEVEL  = 8'h40;
      ifc.TRIG_RISING = 1'b1;
      arm();
      wait_adc("ign_reach_3e", 8'h3E, 400);
      arm();
      wait_done("ign_done", 150);
      rd_chk("ign_rd4", 4'd4, 8'h40);
      rd_chk("ign_rd0", 4'd0, 8'h3C);

      // Reset during POST, then a clean capture
      set_ramp(0, 8'h30);
      arm();
      wait_adc("abort_reach_44", 8'h44, 400);
      chk("abort_busy_in_post", 32'(ifc.BUSY), 32'd1);
      rst = 1'b1;
      tick();
      chk("abort_busy", 32'(ifc.BUSY), 32'd0);
      chk("abort_done", 32'(ifc.DONE), 32'd0);
      rst = 1'b0;
      repeat (100) tick();
      chk("abort_stays_idle", 32'(ifc.DONE | ifc.BUSY), 32'd0);
      set_ramp(0, 8'h10);
      ifc.TRIG_LEVEL = 8'h20;
      arm();
      wait_done("rearm_done", 1000);
      rd_chk("rearm_rd0", 4'd0, 8'h1C);
      rd_chk("rearm_rd4", 4'd4, 8'h20);
      rd_chk("rearm_rd15", 4'd15, 8'h2B);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
